// File: rtl/riscv_trace_buffer_if.sv
// riscv_trace_buffer_if: core trace inputs plus the record drain port of the trace buffer.
interface riscv_trace_buffer_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 9,
   parameter int DEPTH  = 16,
   parameter int TS_W   = 16
);
   localparam int REC_W = TS_W + 1 + 5 + DATA_W + 2 + ADDR_W + DATA_W;
   logic                       reg_write_sig;
   logic [4:0]                 reg_num;
   logic [DATA_W-1:0]          reg_data;
   logic                       wr;
   logic                       rd;
   logic [ADDR_W-1:0]          addr;
   logic [DATA_W-1:0]          wr_data;
   logic [DATA_W-1:0]          rd_data;
   logic                       flush;
   logic                       out_valid;
   logic                       out_ready;
   logic [REC_W-1:0]           out_data;
   logic [$clog2(DEPTH):0]     level;
   logic                       overflow;
   logic [15:0]                drop_count;
   modport master (
      output reg_write_sig, reg_num, reg_data, wr, rd, addr, wr_data, rd_data, flush, out_ready,
      input  out_valid, out_data, level, overflow, drop_count
   );
   modport slave (
      input  reg_write_sig, reg_num, reg_data, wr, rd, addr, wr_data, rd_data, flush, out_ready,
      output out_valid, out_data, level, overflow, drop_count
   );
endinterface

// File: rtl/riscv_trace_buffer.sv
// riscv_trace_buffer: timestamps core trace events into a FIFO that never stalls the core.
module riscv_trace_buffer #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 9,
   parameter int DEPTH  = 16,
   parameter int TS_W   = 16
) (
   input logic              clk,
   input logic              reset,
   riscv_trace_buffer_if.slave t
);
   localparam int AW    = $clog2(DEPTH);
   localparam int REC_W = TS_W + 1 + 5 + DATA_W + 2 + ADDR_W + DATA_W;
   logic [REC_W-1:0]  mem [DEPTH];
   logic [AW:0]       wr_ptr, rd_ptr, level;
   logic [TS_W-1:0]   ts;
   logic              overflow;
   logic [15:0]       drop_count;
   logic              rw, cap, full, empty, pop, push, drop;
   logic [DATA_W-1:0] mdata;
   logic [REC_W-1:0]  rec;
   always_comb begin
      rw    = t.reg_write_sig && (t.reg_num != 5'd0);
      cap   = rw | t.wr | t.rd;
      mdata = t.wr ? t.wr_data : t.rd ? t.rd_data : '0;
      rec   = {ts, rw, t.reg_num, t.reg_data, t.wr, t.rd, t.addr, mdata};
      full  = level == (AW+1)'(DEPTH);
      empty = level == '0;
      pop   = !empty & t.out_ready;
      push  = cap & (!full | pop);
      drop  = cap & full & !pop;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         ts         <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else begin
         ts <= ts + TS_W'(1);
         if (t.flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
            level <= (push & !pop) ? level + (AW+1)'(1) : (pop & !push) ? level - (AW+1)'(1) : level;
            if (drop) begin
               overflow   <= 1'b1;
               drop_count <= drop_count + {15'd0, drop_count != 16'hFFFF};
            end
         end
      end
   end
   // storage carries no reset; only the pointers define which entries are live
   always_ff @(posedge clk)
      if (push & !t.flush & !reset) mem[wr_ptr[AW-1:0]] <= rec;
   assign t.out_valid  = !empty;
   assign t.out_data   = mem[rd_ptr[AW-1:0]];
   assign t.level      = level;
   assign t.overflow   = overflow;
   assign t.drop_count = drop_count;
endmodule

// File: tb/tb_riscv_trace_buffer.sv
// tb_riscv_trace_buffer: directed and random trace traffic checked against a queue model.
module tb_riscv_trace_buffer;
   localparam int DEPTH = 16;
   localparam int REC_W = 16 + 1 + 5 + 32 + 2 + 9 + 32;
   logic clk = 0, reset = 1;
   int   ncmp = 0, nerr = 0;
   riscv_trace_buffer_if #(.DATA_W(32), .ADDR_W(9), .DEPTH(DEPTH), .TS_W(16)) t ();
   riscv_trace_buffer #(.DATA_W(32), .ADDR_W(9), .DEPTH(DEPTH), .TS_W(16)) dut (.clk(clk), .reset(reset), .t(t));
   always #5 clk = ~clk;
   logic [REC_W-1:0] q[$];
   logic [15:0]      ts_m = 0, dc_m = 0;
   bit               ov_m = 0;
   task automatic cmp(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask
   task automatic check();
      cmp("out_valid", 128'(t.out_valid), 128'(q.size() != 0));
      cmp("level", 128'(t.level), 128'(q.size()));
      cmp("overflow", 128'(t.overflow), 128'(ov_m));
      cmp("drop_count", 128'(t.drop_count), 128'(dc_m));
      if (q.size() != 0) cmp("out_data", 128'(t.out_data), 128'(q[0]));
   endtask
   // model one clock edge from the currently driven inputs, then advance the DUT
   task automatic tick(input bit chk);
      bit rw, cap, full, pop;
      logic [31:0] md;
      logic [REC_W-1:0] r;
      rw   = t.reg_write_sig && t.reg_num != 0;
      cap  = rw || t.wr || t.rd;
      md   = t.wr ? t.wr_data : (t.rd ? t.rd_data : 32'd0);
      r    = {ts_m, rw, t.reg_num, t.reg_data, t.wr, t.rd, t.addr, md};
      full = q.size() == DEPTH;
      pop  = q.size() != 0 && t.out_ready;
      if (reset) begin
         q.delete(); ts_m = 0; ov_m = 0; dc_m = 0;
      end else begin
         ts_m = ts_m + 1;
         if (t.flush) begin
            q.delete(); ov_m = 0; dc_m = 0;
         end else begin
            if (pop) void'(q.pop_front());
            if (cap && (!full || pop)) q.push_back(r);
            else if (cap) begin
               ov_m = 1;
               if (dc_m != 16'hFFFF) dc_m = dc_m + 1;
            end
         end
      end
      @(posedge clk); #1;
      if (chk) check();
   endtask
   task automatic idle();
      t.reg_write_sig = 0; t.reg_num = 0; t.reg_data = 0; t.wr = 0; t.rd = 0;
      t.addr = 0; t.wr_data = 0; t.rd_data = 0; t.flush = 0;
   endtask
   initial begin
      idle(); t.out_ready = 0;
      reset = 1; tick(0); tick(0); reset = 0;
      check();
      // 1: single writeback captured at ts=3
      t.out_ready = 1;
      repeat (3) tick(1);
      t.reg_write_sig = 1; t.reg_num = 5; t.reg_data = 32'hDEAD_BEEF;
      tick(1);
      cmp("t1_record", 128'(t.out_data), 128'({16'd3, 1'b1, 5'd5, 32'hDEAD_BEEF, 2'b00, 9'd0, 32'd0}));
      idle(); tick(1);
      cmp("t1_level", 128'(t.level), 128'd0);
      // 2: x0 write filtered, then alongside a memory write
      t.reg_write_sig = 1; t.reg_num = 0; tick(1);
      cmp("t2_nocap", 128'(t.level), 128'd0);
      t.wr = 1; t.addr = 9'h1F0; t.wr_data = 32'h1234; t.out_ready = 0; tick(1);
      cmp("t2_rec", 128'(t.out_data[72:0]), 128'({1'b0, 32'd0, 2'b10, 9'h1F0, 32'h1234}));
      // 3: overflow with consumer stalled, then drain
      idle(); t.flush = 1; tick(1); t.flush = 0;
      for (int i = 0; i < DEPTH + 3; i++) begin
         t.rd = 1; t.addr = 9'($urandom); t.rd_data = $urandom; tick(1);
      end
      idle();
      cmp("t3_dc", 128'(t.drop_count), 128'd3);
      cmp("t3_ov", 128'(t.overflow), 128'd1);
      // 4: full FIFO with simultaneous pop and capture
      t.rd = 1; t.rd_data = 32'hCAFE_F00D; t.out_ready = 1; tick(1);
      cmp("t4_level", 128'(t.level), 128'(DEPTH));
      cmp("t4_nodrop", 128'(t.drop_count), 128'd3);
      idle(); repeat (DEPTH + 1) tick(1);
      // 5: steady push/pop across pointer wrap, then timestamp wrap
      for (int i = 0; i < 3 * DEPTH; i++) begin
         t.wr = 1; t.addr = 9'($urandom); t.wr_data = $urandom; tick(1);
      end
      idle(); tick(1);
      repeat (16'(16'hFFFD - ts_m)) tick(0);
      t.out_ready = 0;
      for (int i = 0; i < 5; i++) begin
         t.reg_write_sig = 1; t.reg_num = 5'($urandom_range(1, 31)); t.reg_data = $urandom; tick(1);
      end
      idle(); t.out_ready = 1;
      repeat (6) tick(1);
      // 6: flush wins over capture with level 7 and overflow set
      t.out_ready = 0;
      repeat (DEPTH + 1) begin t.rd = 1; t.rd_data = $urandom; tick(1); end
      idle(); t.out_ready = 1;
      repeat (DEPTH - 7) tick(1);
      t.out_ready = 0;
      cmp("t6_pre_level", 128'(t.level), 128'd7);
      t.flush = 1; t.wr = 1; t.wr_data = 32'h5555; tick(1);
      idle();
      cmp("t6_level", 128'(t.level), 128'd0);
      cmp("t6_valid", 128'(t.out_valid), 128'd0);
      cmp("t6_ov", 128'(t.overflow), 128'd0);
      cmp("t6_dc", 128'(t.drop_count), 128'd0);
      // random traffic including occasional flush and reset
      for (int i = 0; i < 600; i++) begin
         t.reg_write_sig = 1'($urandom); t.reg_num = 5'($urandom); t.reg_data = $urandom;
         t.wr = ($urandom % 4) == 0; t.rd = ($urandom % 4) == 0; t.addr = 9'($urandom);
         t.wr_data = $urandom; t.rd_data = $urandom;
         t.out_ready = ($urandom % 3) == 0; t.flush = ($urandom % 60) == 0;
         reset = ($urandom % 150) == 0;
         tick(1);
      end
      reset = 0; idle(); t.out_ready = 1;
      repeat (DEPTH + 2) tick(1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule
